mc_d0fifo: RTL and testbench
============================

Name: mc_d0fifo

Overview:
- Multi-channel zero-latency FIFO: CH independent queues, each DEPTH entries, sharing one flop-array storage block.
- Per channel: push/pop/flush, fill-level output, runtime-programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags.
- Empty-queue bypass: when a queue is empty, wdata passes straight to rdata.
- Sits between multi-stream producers and consumers, e.g. per-antenna or per-lane sample buffering, in place of CH separate single-channel FIFOs.

Parameters:
- WIDTH, 16, data bits per entry.
- DEPTH, 32, entries per channel. Must be a power of 2 and at least 2.
- CH, 4, number of independent channels.
- AW, $clog2(DEPTH), derived, not overridable. Address width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset. Asynchronous, active-low.
- push  in  CH  per-channel write request.
- pop  in  CH  per-channel read request.
- flush  in  CH  per-channel synchronous clear.
- wdata  in  CH*WIDTH  write data. Channel c occupies bits [c*WIDTH +: WIDTH].
- al_full_th  in  AW+1  almost-full threshold, shared by all channels. 0 disables al_full.
- al_empty_th  in  AW+1  almost-empty threshold, shared by all channels.
- err_clr  in  1  clears all sticky error flags.
- rdata  out  CH*WIDTH  head data per channel.
- level  out  CH*(AW+1)  entry count per channel, range 0..DEPTH.
- full  out  CH  level==DEPTH.
- empty  out  CH  level==0.
- al_full  out  CH  level>=al_full_th and al_full_th!=0.
- al_empty  out  CH  level<=al_empty_th.
- ack  out  CH  this cycle's push accepted.
- valid  out  CH  rdata is meaningful this cycle.
- ovf  out  CH  sticky overflow flag.
- udf  out  CH  sticky underflow flag.

Behaviour:
- Per-channel state: rd_ptr and wr_ptr, each AW+1 bits, wrapping modulo 2^(AW+1).
- Derived per channel:
  - level = wr_ptr - rd_ptr, computed modulo 2^(AW+1).
  - Memory address = pointer[AW-1:0].
  - The MSB distinguishes full from empty.
- All status outputs (full, empty, al_full, al_empty, level) are combinational from registered pointers only. They do not depend on the same-cycle push or pop.
- Write enable: wen = push & (!full | pop) & !flush.
  - On wen, mem[ch][wr_ptr] <= wdata on the clock edge, and wr_ptr increments.
  - Push to a full queue with a simultaneous pop is accepted.
- Read enable: ren = pop & !empty & !flush.
  - On ren, rd_ptr increments.
  - rdata = empty ? wdata : mem[ch][rd_ptr]. There is zero read latency: the head is visible combinationally.
- Bypass: when empty & push & pop & !flush, the word is consumed in the same cycle.
  - rdata = wdata, ack=1, valid=1.
  - Neither pointer moves, and the memory is not written.
- ack = (wen & !bypass) | bypass, i.e. push & !flush & (!full | pop).
- valid = !flush & (!empty | push).
- Flush:
  - On the next edge, rd_ptr and wr_ptr reset to 0.
  - Same-cycle push and pop are ignored; ack=0, valid=0.
  - Memory contents are not cleared.
  - Error flags are unaffected.
- Overflow: ovf[c] sets on push & full & !pop & !flush. The data is dropped and the pointers are unchanged.
- Underflow: udf[c] sets on pop & empty & !push & !flush. rd_ptr is unchanged.
- err_clr clears all ovf and udf bits on the next edge. If a set and err_clr occur in the same cycle, the set wins.
- Channels are fully independent. Any combination of push, pop and flush across channels is legal in the same cycle.
- Thresholds are sampled combinationally. Changing them mid-stream updates al_full and al_empty in the same cycle.
- Reset:
  - All pointers and sticky flags go to 0.
  - Resulting outputs: empty=all 1, full=0, level=0, ovf=0, udf=0, al_full=0 (level 0 can never reach a nonzero threshold), al_empty=all 1.
  - ack = valid = 0 unless push is asserted; with empty=1 and push, rdata = wdata.
  - Memory is not reset.
  - Reset asserted mid-operation discards all queued data immediately and asynchronously.
- Wrap-around: after 2^(AW+1) pushes and matching pops the pointers return to 0. level stays correct across the wrap.

Test Plan:
(Configuration for all scenarios: WIDTH=8, DEPTH=4, CH=2, al_full_th=3, al_empty_th=1.)
1. Reset, then push 0x11,0x22,0x33,0x44 on ch0 -> level0 goes 1,2,3,4; al_full at level 3; full=1 at 4; ch1 stays empty=1, level=0.
2. ch0 full, push 0x55 without pop -> ack0=0, ovf0=1 sticky, level0=4. Then pop 4 times -> rdata sequence 0x11,0x22,0x33,0x44, then empty=1, al_empty=1.
3. ch1 empty, push=pop=1 with wdata=0xA5 -> rdata1=0xA5, ack1=1, valid1=1, level1 stays 0. Pop alone on the next cycle -> udf1=1.
4. ch0 full, push 0x66 and pop together -> rdata0=head 0x11, ack0=1, level0 stays 4. Later reads return 0x22,0x33,0x44,0x66.
5. ch0 holding 3 entries, flush0=1 with push0=1 -> ack0=0. Next cycle level0=0, empty0=1; ch1 level unchanged.
6. 40 interleaved push/pop pairs on ch1 (pointer wrap) with err_clr pulsed -> data order preserved, level1 correct throughout, ovf and udf clear after err_clr.

Source files
------------

// File: rtl/mc_d0fifo.sv
// mc_d0fifo: multi-channel zero-latency FIFO with empty-queue bypass and per-channel status
module mc_d0fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 32,
    parameter int CH    = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CH-1:0]       push,
    input  logic [CH-1:0]       pop,
    input  logic [CH-1:0]       flush,
    input  logic [CH*WIDTH-1:0] wdata,
    input  logic [AW:0]         al_full_th,
    input  logic [AW:0]         al_empty_th,
    input  logic                err_clr,
    output logic [CH*WIDTH-1:0] rdata,
    output logic [CH*(AW+1)-1:0] level,
    output logic [CH-1:0]       full,
    output logic [CH-1:0]       empty,
    output logic [CH-1:0]       al_full,
    output logic [CH-1:0]       al_empty,
    output logic [CH-1:0]       ack,
    output logic [CH-1:0]       valid,
    output logic [CH-1:0]       ovf,
    output logic [CH-1:0]       udf
);
    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [WIDTH-1:0] mem [DEPTH];
        logic [AW:0]      wr_ptr, rd_ptr, lvl;
        logic [WIDTH-1:0] din;
        logic             is_full, is_empty, byp, wr, rd, ovf_r, udf_r;
        assign din      = wdata[c*WIDTH +: WIDTH];
        // Status comes from the registered pointers only; the extra MSB separates full from empty
        assign lvl      = wr_ptr - rd_ptr;
        assign is_full  = lvl == (AW+1)'(DEPTH);
        assign is_empty = lvl == '0;
        // An empty queue with push and pop hands the word straight through without touching storage
        assign byp      = is_empty & push[c] & pop[c] & ~flush[c];
        assign wr       = push[c] & (~is_full | pop[c]) & ~flush[c] & ~byp;
        assign rd       = pop[c] & ~is_empty & ~flush[c];
        assign rdata[c*WIDTH +: WIDTH] = is_empty ? din : mem[rd_ptr[AW-1:0]];
        assign level[c*(AW+1) +: AW+1] = lvl;
        assign full[c]     = is_full;
        assign empty[c]    = is_empty;
        assign al_full[c]  = (al_full_th != '0) && (lvl >= al_full_th);
        assign al_empty[c] = lvl <= al_empty_th;
        assign ack[c]      = push[c] & ~flush[c] & (~is_full | pop[c]);
        assign valid[c]    = ~flush[c] & (~is_empty | push[c]);
        assign ovf[c]      = ovf_r;
        assign udf[c]      = udf_r;
        // Storage write; contents survive reset and flush
        always_ff @(posedge clk) begin
            if (wr) mem[wr_ptr[AW-1:0]] <= din;
        end
        // Pointer advance, flush clear and sticky error flags (a new error beats err_clr)
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                ovf_r  <= 1'b0;
                udf_r  <= 1'b0;
            end else begin
                ovf_r <= (push[c] & is_full & ~pop[c] & ~flush[c]) | (ovf_r & ~err_clr);
                udf_r <= (pop[c] & is_empty & ~push[c] & ~flush[c]) | (udf_r & ~err_clr);
                if (flush[c]) begin
                    wr_ptr <= '0;
                    rd_ptr <= '0;
                end else begin
                    if (wr) wr_ptr <= wr_ptr + 1'b1;
                    if (rd) rd_ptr <= rd_ptr + 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_mc_d0fifo.sv
// tb_mc_d0fifo: directed self-checking bench for mc_d0fifo (WIDTH=8, DEPTH=4, CH=2)
module tb_mc_d0fifo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  push = '0, pop = '0, flush = '0;
    logic [15:0] wdata = '0;
    logic [2:0]  al_full_th = 3'd3, al_empty_th = 3'd1;
    logic        err_clr = 1'b0;
    logic [15:0] rdata;
    logic [5:0]  level;
    logic [1:0]  full, empty, al_full, al_empty, ack, valid, ovf, udf;
    int checks = 0, errors = 0;

    mc_d0fifo #(.WIDTH(8), .DEPTH(4), .CH(2)) dut (
        .clk(clk), .rst_n(rst_n), .push(push), .pop(pop), .flush(flush), .wdata(wdata),
        .al_full_th(al_full_th), .al_empty_th(al_empty_th), .err_clr(err_clr),
        .rdata(rdata), .level(level), .full(full), .empty(empty), .al_full(al_full),
        .al_empty(al_empty), .ack(ack), .valid(valid), .ovf(ovf), .udf(udf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_level", 32'(level), 32'h0);
        chk("rst_alfull", 32'(al_full), 32'h0);
        chk("rst_alempty", 32'(al_empty), 32'h3);
        chk("rst_err", 32'({ovf, udf}), 32'h0);
        chk("rst_ackvalid", 32'({ack, valid}), 32'h0);
        #10 rst_n = 1'b1;
        cyc();
        // 1: fill ch0
        for (int i = 0; i < 4; i++) begin
            push = 2'b01;
            wdata[7:0] = 8'(8'h11 * (i + 1));
            #1;
            chk("t1_ack", 32'(ack[0]), 32'h1);
            cyc();
            chk("t1_level", 32'(level[2:0]), 32'(i + 1));
            chk("t1_alfull", 32'(al_full[0]), 32'(i + 1 >= 3));
            chk("t1_alempty", 32'(al_empty[0]), 32'(i + 1 <= 1));
            chk("t1_full", 32'(full[0]), 32'(i == 3));
        end
        push = 2'b00;
        #1;
        chk("t1_ch1_empty", 32'(empty[1]), 32'h1);
        chk("t1_ch1_level", 32'(level[5:3]), 32'h0);
        // 2: overflow then drain
        push = 2'b01;
        wdata[7:0] = 8'h55;
        #1;
        chk("t2_ack", 32'(ack[0]), 32'h0);
        cyc();
        push = 2'b00;
        chk("t2_ovf", 32'(ovf[0]), 32'h1);
        chk("t2_level", 32'(level[2:0]), 32'h4);
        for (int i = 0; i < 4; i++) begin
            pop = 2'b01;
            #1;
            chk("t2_rdata", 32'(rdata[7:0]), 32'(8'h11 * (i + 1)));
            chk("t2_valid", 32'(valid[0]), 32'h1);
            cyc();
        end
        pop = 2'b00;
        chk("t2_empty", 32'(empty[0]), 32'h1);
        chk("t2_alempty", 32'(al_empty[0]), 32'h1);
        chk("t2_ovf_sticky", 32'(ovf[0]), 32'h1);
        // 3: bypass then underflow on ch1
        push = 2'b10;
        pop = 2'b10;
        wdata[15:8] = 8'hA5;
        #1;
        chk("t3_rdata", 32'(rdata[15:8]), 32'hA5);
        chk("t3_ack", 32'(ack[1]), 32'h1);
        chk("t3_valid", 32'(valid[1]), 32'h1);
        cyc();
        chk("t3_level", 32'(level[5:3]), 32'h0);
        push = 2'b00;
        #1;
        chk("t3_novalid", 32'(valid[1]), 32'h0);
        cyc();
        pop = 2'b00;
        chk("t3_udf", 32'(udf[1]), 32'h1);
        // 4: push+pop on full ch0
        for (int i = 0; i < 4; i++) begin
            push = 2'b01;
            wdata[7:0] = 8'(8'h11 * (i + 1));
            cyc();
        end
        push = 2'b01;
        pop = 2'b01;
        wdata[7:0] = 8'h66;
        #1;
        chk("t4_rdata", 32'(rdata[7:0]), 32'h11);
        chk("t4_ack", 32'(ack[0]), 32'h1);
        cyc();
        push = 2'b00;
        chk("t4_level", 32'(level[2:0]), 32'h4);
        chk("t4_full", 32'(full[0]), 32'h1);
        for (int i = 0; i < 4; i++) begin
            pop = 2'b01;
            #1;
            chk("t4_rdata_seq", 32'(rdata[7:0]), (i == 3) ? 32'h66 : 32'(8'h11 * (i + 2)));
            cyc();
        end
        pop = 2'b00;
        chk("t4_empty", 32'(empty[0]), 32'h1);
        // 5: flush ch0 with push, ch1 untouched
        for (int i = 0; i < 3; i++) begin
            push = (i == 0) ? 2'b11 : 2'b01;
            wdata = {8'h99, 8'(8'h77 + i)};
            cyc();
        end
        flush = 2'b01;
        push = 2'b01;
        #1;
        chk("t5_ack", 32'(ack[0]), 32'h0);
        chk("t5_valid", 32'(valid[0]), 32'h0);
        cyc();
        flush = 2'b00;
        push = 2'b00;
        chk("t5_level", 32'(level[2:0]), 32'h0);
        chk("t5_empty", 32'(empty[0]), 32'h1);
        chk("t5_ch1_level", 32'(level[5:3]), 32'h1);
        chk("t5_ovf_kept", 32'(ovf[0]), 32'h1);
        pop = 2'b10;
        wdata[15:8] = 8'h00;
        #1;
        chk("t5_ch1_rdata", 32'(rdata[15:8]), 32'h99);
        cyc();
        pop = 2'b00;
        // set beats err_clr: ch0 underflow in the same cycle as err_clr
        pop = 2'b01;
        err_clr = 1'b1;
        cyc();
        pop = 2'b00;
        err_clr = 1'b0;
        chk("set_wins_udf0", 32'(udf[0]), 32'h1);
        chk("clr_ovf0", 32'(ovf[0]), 32'h0);
        chk("clr_udf1", 32'(udf[1]), 32'h0);
        // 6: streaming with pointer wrap on ch1
        push = 2'b10;
        wdata[15:8] = 8'd1;
        cyc();
        for (int k = 1; k <= 40; k++) begin
            push = 2'b10;
            pop = 2'b10;
            wdata[15:8] = 8'(k + 1);
            err_clr = (k == 20);
            #1;
            chk("t6_rdata", 32'(rdata[15:8]), 32'(k));
            cyc();
            chk("t6_level", 32'(level[5:3]), 32'h1);
        end
        push = 2'b00;
        err_clr = 1'b0;
        #1;
        chk("t6_last", 32'(rdata[15:8]), 32'd41);
        pop = 2'b10;
        cyc();
        pop = 2'b00;
        chk("t6_empty", 32'(empty[1]), 32'h1);
        chk("t6_err", 32'({ovf, udf}), 32'h0);
        // asynchronous reset discards queued data without a clock edge
        push = 2'b11;
        wdata = 16'h1234;
        cyc();
        push = 2'b00;
        chk("pre_rst_level", 32'(level), 32'h9);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_level", 32'(level), 32'h0);
        chk("async_rst_empty", 32'(empty), 32'h3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
